// File: rtl/ha1588_pkg.sv
// Shared definitions for the IEEE 1588 hardware-assist core: register map,
// control/status bit positions, RTC constants and the timestamp entry layout.
package ha1588_pkg;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_STATUS    = 8'h04;
  localparam logic [7:0] ADDR_SEC_H     = 8'h08;
  localparam logic [7:0] ADDR_SEC_L     = 8'h0C;
  localparam logic [7:0] ADDR_NS        = 8'h10;
  localparam logic [7:0] ADDR_PERIOD    = 8'h14;
  localparam logic [7:0] ADDR_ADJ       = 8'h18;
  localparam logic [7:0] ADDR_RX_SEC_H  = 8'h20;
  localparam logic [7:0] ADDR_RX_SEC_L  = 8'h24;
  localparam logic [7:0] ADDR_RX_NS     = 8'h28;
  localparam logic [7:0] ADDR_RX_INFO   = 8'h2C;
  localparam logic [7:0] ADDR_TX_SEC_H  = 8'h30;
  localparam logic [7:0] ADDR_TX_SEC_L  = 8'h34;
  localparam logic [7:0] ADDR_TX_NS     = 8'h38;
  localparam logic [7:0] ADDR_TX_INFO   = 8'h3C;

  localparam int CTRL_LOAD_TIME   = 0;
  localparam int CTRL_LOAD_PERIOD = 1;
  localparam int CTRL_ADJ_TIME    = 2;
  localparam int CTRL_SNAPSHOT    = 3;
  localparam int CTRL_RX_POP      = 4;
  localparam int CTRL_TX_POP      = 5;

  localparam int STAT_RX_NE  = 0;
  localparam int STAT_TX_NE  = 1;
  localparam int STAT_RX_OVF = 2;
  localparam int STAT_TX_OVF = 3;

  localparam logic [31:0] NS_PER_SEC    = 32'd1_000_000_000;
  localparam logic [15:0] PTP_ETHERTYPE = 16'h88F7;

  // 98-bit entry: nanoseconds never exceed 10^9, so 30 bits suffice
  typedef struct packed {
    logic [47:0] sec;
    logic [29:0] ns;
    logic [15:0] seq_id;
    logic [3:0]  msg_type;
  } ts_entry_t;

  function automatic logic [31:0] info_word(input ts_entry_t e);
    return {e.seq_id, 8'h00, e.msg_type, 4'h0};
  endfunction

endpackage

// File: rtl/ha1588_tsu.sv
// Timestamp unit for one GMII direction: PTP event frame parser feeding a
// small FIFO of {sec, ns, seqId, msgType} entries.
module ha1588_tsu
  import ha1588_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_ctrl,
  input  logic [7:0]  gmii_data,
  input  logic [47:0] rtc_sec,
  input  logic [29:0] rtc_ns,
  input  logic        pop,
  input  logic        clr_ovf,
  output ts_entry_t   head,
  output logic        nonempty,
  output logic        ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, SFD, BODY} state_t;

  state_t      state, state_nxt;
  logic        sfd_hit, body_byte, push;
  logic [5:0]  byte_cnt;
  logic        ev_ok;
  logic [3:0]  msg_type;
  logic [7:0]  seq_hi;
  logic [47:0] ts_sec;
  logic [29:0] ts_ns;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sfd_hit   = 1'b0;
    body_byte = 1'b0;
    if (!gmii_ctrl) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (gmii_data == 8'h55) state_nxt = PREAMBLE;
        PREAMBLE: state_nxt = (gmii_data == 8'h55) ? SFD : IDLE;
        SFD: begin
          if (gmii_data == 8'hD5) begin
            state_nxt = BODY;
            sfd_hit   = 1'b1;
          end else if (gmii_data != 8'h55) begin
            state_nxt = IDLE;
          end
        end
        BODY:     body_byte = 1'b1;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // ev_ok starts optimistic at the SFD and is knocked down by any header byte that disqualifies the frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      ev_ok    <= 1'b0;
    end else if (sfd_hit) begin
      byte_cnt <= '0;
      ev_ok    <= 1'b1;
    end else if (body_byte) begin
      if (byte_cnt != 6'h3F) byte_cnt <= byte_cnt + 6'd1;
      if ((byte_cnt == 6'd12 && gmii_data != PTP_ETHERTYPE[15:8]) ||
          (byte_cnt == 6'd13 && gmii_data != PTP_ETHERTYPE[7:0])  ||
          (byte_cnt == 6'd14 && gmii_data[3:0] >= 4'd4))
        ev_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sfd_hit) begin
      ts_sec <= rtc_sec;
      ts_ns  <= rtc_ns;
    end
    if (body_byte && byte_cnt == 6'd14) msg_type <= gmii_data[3:0];
    if (body_byte && byte_cnt == 6'd44) seq_hi   <= gmii_data;
  end

  assign push = body_byte && (byte_cnt == 6'd45) && ev_ok;

  ts_entry_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, do_push, do_pop;

  assign full     = (count == CNT_FULL);
  assign nonempty = (count != '0);
  assign do_pop   = pop && nonempty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push && !do_push) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{sec: ts_sec, ns: ts_ns, seq_id: {seq_hi, gmii_data}, msg_type: msg_type};
  end

  assign head = nonempty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ha1588_core.sv
// IEEE 1588 hardware-assist core: fractional-period RTC with load/adjust,
// register bank, and one timestamp unit per GMII direction.
module ha1588_core
  import ha1588_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] PERIOD_RST = 32'h0800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_in,
  input  logic        rd_in,
  input  logic [7:0]  addr_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] rtc_time_ptp_ns,
  output logic [47:0] rtc_time_ptp_sec,
  input  logic        rx_gmii_ctrl,
  input  logic [7:0]  rx_gmii_data,
  input  logic        tx_gmii_ctrl,
  input  logic [7:0]  tx_gmii_data
);

  logic [47:0]        sec_q, snap_sec;
  logic [31:0]        ns_q, snap_ns;
  logic [23:0]        frac_q;
  logic [31:0]        period_q, period_stg;
  logic [15:0]        sec_h_stg;
  logic [31:0]        sec_l_stg, ns_stg;
  logic signed [31:0] adj_q;

  logic wr_ctrl, ld_time, ld_period, adj_time, snapshot, rx_pop, tx_pop;
  logic wr_stat, rx_clr, tx_clr;

  assign wr_ctrl   = wr_in && (addr_in == ADDR_CTRL);
  assign ld_time   = wr_ctrl && data_in[CTRL_LOAD_TIME];
  assign ld_period = wr_ctrl && data_in[CTRL_LOAD_PERIOD];
  assign adj_time  = wr_ctrl && data_in[CTRL_ADJ_TIME];
  assign snapshot  = wr_ctrl && data_in[CTRL_SNAPSHOT];
  assign rx_pop    = wr_ctrl && data_in[CTRL_RX_POP];
  assign tx_pop    = wr_ctrl && data_in[CTRL_TX_POP];
  assign wr_stat   = wr_in && (addr_in == ADDR_STATUS);
  assign rx_clr    = wr_stat && data_in[STAT_RX_OVF];
  assign tx_clr    = wr_stat && data_in[STAT_TX_OVF];

  logic [24:0]        frac_sum;
  logic [31:0]        ns_inc, ns_norm, ns_nxt;
  logic [47:0]        sec_norm, sec_nxt;
  logic signed [33:0] adj_sum;

  // The adjustment rides on top of this cycle's normal increment so no period is lost
  always_comb begin
    frac_sum = {1'b0, frac_q} + {1'b0, period_q[23:0]};
    ns_inc   = ns_q + {24'h0, period_q[31:24]} + {31'h0, frac_sum[24]};
    ns_norm  = ns_inc;
    sec_norm = sec_q;
    if (ns_inc >= NS_PER_SEC) begin
      ns_norm  = ns_inc - NS_PER_SEC;
      sec_norm = sec_q + 48'd1;
    end
    adj_sum = $signed({2'b00, ns_norm}) + $signed({{2{adj_q[31]}}, adj_q});
    ns_nxt  = ns_norm;
    sec_nxt = sec_norm;
    if (adj_time) begin
      ns_nxt = adj_sum[31:0];
      if (adj_sum >= $signed({2'b00, NS_PER_SEC})) begin
        ns_nxt  = adj_sum[31:0] - NS_PER_SEC;
        sec_nxt = sec_norm + 48'd1;
      end else if (adj_sum < 34'sd0) begin
        ns_nxt  = adj_sum[31:0] + NS_PER_SEC;
        sec_nxt = sec_norm - 48'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q    <= '0;
      ns_q     <= '0;
      frac_q   <= '0;
      period_q <= PERIOD_RST;
    end else begin
      if (ld_time) begin
        sec_q  <= {sec_h_stg, sec_l_stg};
        ns_q   <= ns_stg;
        frac_q <= '0;
      end else begin
        sec_q  <= sec_nxt;
        ns_q   <= ns_nxt;
        frac_q <= frac_sum[23:0];
      end
      if (ld_period) period_q <= period_stg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_h_stg  <= '0;
      sec_l_stg  <= '0;
      ns_stg     <= '0;
      period_stg <= '0;
      adj_q      <= '0;
      snap_sec   <= '0;
      snap_ns    <= '0;
    end else begin
      if (wr_in && addr_in == ADDR_SEC_H)  sec_h_stg  <= data_in[15:0];
      if (wr_in && addr_in == ADDR_SEC_L)  sec_l_stg  <= data_in;
      if (wr_in && addr_in == ADDR_NS)     ns_stg     <= data_in;
      if (wr_in && addr_in == ADDR_PERIOD) period_stg <= data_in;
      if (wr_in && addr_in == ADDR_ADJ)    adj_q      <= $signed(data_in);
      if (snapshot) begin
        snap_sec <= sec_q;
        snap_ns  <= ns_q;
      end
    end
  end

  assign rtc_time_ptp_ns  = ns_q;
  assign rtc_time_ptp_sec = sec_q;

  ts_entry_t rx_head, tx_head;
  logic      rx_ne, tx_ne, rx_ovf, tx_ovf;

  ha1588_tsu #(.FIFO_DEPTH(FIFO_DEPTH)) u_rx_tsu (
    .clk(clk), .rst(rst), .gmii_ctrl(rx_gmii_ctrl), .gmii_data(rx_gmii_data),
    .rtc_sec(sec_q), .rtc_ns(ns_q[29:0]), .pop(rx_pop), .clr_ovf(rx_clr),
    .head(rx_head), .nonempty(rx_ne), .ovf(rx_ovf)
  );

  ha1588_tsu #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_tsu (
    .clk(clk), .rst(rst), .gmii_ctrl(tx_gmii_ctrl), .gmii_data(tx_gmii_data),
    .rtc_sec(sec_q), .rtc_ns(ns_q[29:0]), .pop(tx_pop), .clr_ovf(tx_clr),
    .head(tx_head), .nonempty(tx_ne), .ovf(tx_ovf)
  );

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (addr_in)
      ADDR_STATUS:   rd_mux = {28'h0, tx_ovf, rx_ovf, tx_ne, rx_ne};
      ADDR_SEC_H:    rd_mux = {16'h0, snap_sec[47:32]};
      ADDR_SEC_L:    rd_mux = snap_sec[31:0];
      ADDR_NS:       rd_mux = snap_ns;
      ADDR_PERIOD:   rd_mux = period_q;
      ADDR_ADJ:      rd_mux = adj_q;
      ADDR_RX_SEC_H: rd_mux = {16'h0, rx_head.sec[47:32]};
      ADDR_RX_SEC_L: rd_mux = rx_head.sec[31:0];
      ADDR_RX_NS:    rd_mux = {2'b00, rx_head.ns};
      ADDR_RX_INFO:  rd_mux = info_word(rx_head);
      ADDR_TX_SEC_H: rd_mux = {16'h0, tx_head.sec[47:32]};
      ADDR_TX_SEC_L: rd_mux = tx_head.sec[31:0];
      ADDR_TX_NS:    rd_mux = {2'b00, tx_head.ns};
      ADDR_TX_INFO:  rd_mux = info_word(tx_head);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       data_out <= '0;
    else if (rd_in) data_out <= rd_mux;
  end

endmodule

// File: tb/tb_ha1588_core.sv
// Self-checking bench for ha1588_core: register table, RTC load/adjust/wrap
// sequences and RX/TX frame timestamping with a scoreboard of expected reads.
module tb_ha1588_core;
  import ha1588_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_in = 1'b0, rd_in = 1'b0;
  logic [7:0]  addr_in = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [31:0] rtc_time_ptp_ns;
  logic [47:0] rtc_time_ptp_sec;
  logic        rx_gmii_ctrl = 1'b0, tx_gmii_ctrl = 1'b0;
  logic [7:0]  rx_gmii_data = '0, tx_gmii_data = '0;

  always #5 clk = ~clk;

  ha1588_core #(.FIFO_DEPTH(4), .PERIOD_RST(32'h0800_0000)) dut (
    .clk(clk), .rst(rst), .wr_in(wr_in), .rd_in(rd_in), .addr_in(addr_in),
    .data_in(data_in), .data_out(data_out), .rtc_time_ptp_ns(rtc_time_ptp_ns),
    .rtc_time_ptp_sec(rtc_time_ptp_sec), .rx_gmii_ctrl(rx_gmii_ctrl),
    .rx_gmii_data(rx_gmii_data), .tx_gmii_ctrl(tx_gmii_ctrl), .tx_gmii_data(tx_gmii_data)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] exp; string nm; } sb_t;
  sb_t sb_q[$];

  typedef struct { logic [47:0] sec; logic [31:0] ns; logic [15:0] seq; logic [3:0] msg; } ent_t;
  ent_t rx_exp_q[$];
  ent_t tx_exp_q[$];

  typedef struct { bit is_wr; logic [7:0] a; logic [31:0] d; string nm; } vec_t;
  vec_t tbl[14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_in = 1'b1; addr_in = a; data_in = d;
    @(negedge clk);
    wr_in = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
    sb_t s;
    rd_in = 1'b1; addr_in = a;
    s.exp = e; s.nm = nm;
    sb_q.push_back(s);
    @(negedge clk);
    rd_in = 1'b0;
    s = sb_q.pop_front();
    check(s.nm, {32'h0, data_out}, {32'h0, s.exp});
  endtask

  function automatic logic [31:0] bit32(input int idx);
    logic [31:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic set_byte(input bit tx, input logic c, input logic [7:0] d);
    if (tx) begin tx_gmii_ctrl = c; tx_gmii_data = d; end
    else    begin rx_gmii_ctrl = c; rx_gmii_data = d; end
  endtask

  // Loads a known time, then sends a frame immediately: the SFD is byte 7, so its timestamp is ns + 7*8.
  task automatic ts_frame(input bit tx, input logic [15:0] et, input logic [3:0] msg,
                          input logic [15:0] seq, input int blen,
                          input logic [47:0] sec, input logic [31:0] ns, input bit exp_push);
    ent_t e;
    logic [7:0] b;
    wr(ADDR_SEC_H, {16'h0, sec[47:32]});
    wr(ADDR_SEC_L, sec[31:0]);
    wr(ADDR_NS, ns);
    wr(ADDR_CTRL, bit32(CTRL_LOAD_TIME));
    for (int i = 0; i < 7; i++) begin set_byte(tx, 1'b1, 8'h55); @(negedge clk); end
    set_byte(tx, 1'b1, 8'hD5); @(negedge clk);
    for (int i = 0; i < blen; i++) begin
      b = i[7:0];
      case (i)
        12: b = et[15:8];
        13: b = et[7:0];
        14: b = {4'h0, msg};
        44: b = seq[15:8];
        45: b = seq[7:0];
        default: ;
      endcase
      set_byte(tx, 1'b1, b); @(negedge clk);
    end
    set_byte(tx, 1'b0, 8'h00);
    repeat (12) @(negedge clk);
    if (exp_push) begin
      e.sec = sec; e.ns = ns + 32'd56; e.seq = seq; e.msg = msg;
      if (tx) tx_exp_q.push_back(e); else rx_exp_q.push_back(e);
    end
  endtask

  task automatic chk_head(input bit tx);
    ent_t e;
    logic [7:0] base;
    string p;
    p = tx ? "tx" : "rx";
    base = tx ? ADDR_TX_SEC_H : ADDR_RX_SEC_H;
    if (tx) begin
      if (tx_exp_q.size() == 0) begin check("tx_exp_queue_nonempty", 64'd0, 64'd1); return; end
      e = tx_exp_q.pop_front();
    end else begin
      if (rx_exp_q.size() == 0) begin check("rx_exp_queue_nonempty", 64'd0, 64'd1); return; end
      e = rx_exp_q.pop_front();
    end
    rd(base,         {16'h0, e.sec[47:32]},           $sformatf("%s_head_sec_h", p));
    rd(base + 8'h04, e.sec[31:0],                     $sformatf("%s_head_sec_l", p));
    rd(base + 8'h08, e.ns,                            $sformatf("%s_head_ns", p));
    rd(base + 8'h0C, {e.seq, 8'h00, e.msg, 4'h0},     $sformatf("%s_head_info", p));
    wr(ADDR_CTRL, bit32(tx ? CTRL_TX_POP : CTRL_RX_POP));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ns_a;

    tbl[0]  = '{1'b0, ADDR_STATUS, 32'h0,          "status_after_reset"};
    tbl[1]  = '{1'b0, ADDR_CTRL,   32'h0,          "ctrl_reads_zero"};
    tbl[2]  = '{1'b1, ADDR_NS,     32'd123,        "wr_ns_staging"};
    tbl[3]  = '{1'b0, ADDR_NS,     32'd800,        "ns_reads_snapshot"};
    tbl[4]  = '{1'b1, ADDR_PERIOD, 32'h0C80_0000,  "wr_period_staging"};
    tbl[5]  = '{1'b0, ADDR_PERIOD, 32'h0800_0000,  "period_not_applied"};
    tbl[6]  = '{1'b1, ADDR_ADJ,    32'hFFFF_FF38,  "wr_adj"};
    tbl[7]  = '{1'b0, ADDR_ADJ,    32'hFFFF_FF38,  "adj_readback"};
    tbl[8]  = '{1'b0, 8'h1C,       32'h0,          "unmapped_1c"};
    tbl[9]  = '{1'b1, 8'h40,       32'hDEAD_BEEF,  "wr_unmapped_40"};
    tbl[10] = '{1'b0, 8'h40,       32'h0,          "unmapped_40"};
    tbl[11] = '{1'b0, ADDR_RX_INFO, 32'h0,         "rx_head_empty"};
    tbl[12] = '{1'b0, ADDR_SEC_L,  32'h0,          "snap_sec_l"};
    tbl[13] = '{1'b0, ADDR_PERIOD, 32'h0800_0000,  "period_again"};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rtc_ns",  {32'h0, rtc_time_ptp_ns}, 64'd0);
    check("rst_rtc_sec", {16'h0, rtc_time_ptp_sec}, 64'd0);
    check("rst_data_out", {32'h0, data_out}, 64'd0);
    rst = 1'b1;

    // Free-running RTC at 8 ns per cycle
    rd(ADDR_PERIOD, 32'h0800_0000, "period_reset");
    repeat (99) @(negedge clk);
    check("rtc_ns_100cyc", {32'h0, rtc_time_ptp_ns}, 64'd800);
    wr(ADDR_CTRL, bit32(CTRL_SNAPSHOT));
    rd(ADDR_NS,    32'd800, "snap_ns_800");
    rd(ADDR_SEC_L, 32'd0,   "snap_sec_0");

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].a, tbl[i].d);
      else              rd(tbl[i].a, tbl[i].d, tbl[i].nm);
    end
    repeat (2) @(negedge clk);
    check("data_out_holds", {32'h0, data_out}, 64'h0800_0000);

    // LOAD_TIME and the second rollover
    wr(ADDR_SEC_H, 32'd0);
    wr(ADDR_SEC_L, 32'd5);
    wr(ADDR_NS, 32'd999_999_992);
    wr(ADDR_CTRL, bit32(CTRL_LOAD_TIME));
    check("load_sec", {16'h0, rtc_time_ptp_sec}, 64'd5);
    check("load_ns",  {32'h0, rtc_time_ptp_ns}, 64'd999_999_992);
    @(negedge clk);
    check("roll_sec", {16'h0, rtc_time_ptp_sec}, 64'd6);
    check("roll_ns",  {32'h0, rtc_time_ptp_ns}, 64'd0);

    // Negative and positive adjustments
    wr(ADDR_NS, 32'd100);
    wr(ADDR_SEC_L, 32'd10);
    wr(ADDR_CTRL, bit32(CTRL_LOAD_TIME));
    wr(ADDR_ADJ, -32'sd200);
    wr(ADDR_CTRL, bit32(CTRL_ADJ_TIME));
    check("adj_neg_sec", {16'h0, rtc_time_ptp_sec}, 64'd9);
    check("adj_neg_ns",  {32'h0, rtc_time_ptp_ns}, 64'd999_999_916);
    wr(ADDR_ADJ, 32'd999_999_990);
    wr(ADDR_CTRL, bit32(CTRL_ADJ_TIME));
    check("adj_pos_sec", {16'h0, rtc_time_ptp_sec}, 64'd10);
    check("adj_pos_ns",  {32'h0, rtc_time_ptp_ns}, 64'd999_999_922);

    // LOAD_TIME wins over ADJ_TIME
    wr(ADDR_NS, 32'd500);
    wr(ADDR_SEC_L, 32'd20);
    wr(ADDR_CTRL, bit32(CTRL_LOAD_TIME) | bit32(CTRL_ADJ_TIME));
    check("prio_sec", {16'h0, rtc_time_ptp_sec}, 64'd20);
    check("prio_ns",  {32'h0, rtc_time_ptp_ns}, 64'd500);

    // 48-bit seconds wrap
    wr(ADDR_SEC_H, 32'h0000_FFFF);
    wr(ADDR_SEC_L, 32'hFFFF_FFFF);
    wr(ADDR_NS, 32'd999_999_992);
    wr(ADDR_CTRL, bit32(CTRL_LOAD_TIME));
    check("wrap_sec_max", {16'h0, rtc_time_ptp_sec}, 64'h0000_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("wrap_sec_zero", {16'h0, rtc_time_ptp_sec}, 64'd0);
    check("wrap_ns_zero",  {32'h0, rtc_time_ptp_ns}, 64'd0);

    // Fractional period of 12.5 ns
    wr(ADDR_SEC_H, 32'd0);
    wr(ADDR_SEC_L, 32'd0);
    wr(ADDR_NS, 32'd0);
    wr(ADDR_PERIOD, 32'h0C80_0000);
    wr(ADDR_CTRL, bit32(CTRL_LOAD_TIME) | bit32(CTRL_LOAD_PERIOD));
    ns_a = rtc_time_ptp_ns;
    check("period_load_ns0", {32'h0, ns_a}, 64'd0);
    repeat (2) @(negedge clk);
    check("period_12p5_two_cycles", {32'h0, rtc_time_ptp_ns}, 64'd25);
    rd(ADDR_PERIOD, 32'h0C80_0000, "period_applied");
    wr(ADDR_PERIOD, 32'h0800_0000);
    wr(ADDR_CTRL, bit32(CTRL_LOAD_PERIOD));

    // RX event frame
    ts_frame(1'b0, 16'h88F7, 4'h0, 16'h1234, 60, 48'h0001_0000_0002, 32'd1000, 1'b1);
    rd(ADDR_STATUS, 32'h1, "rx_nonempty");
    chk_head(1'b0);
    rd(ADDR_STATUS, 32'h0, "rx_empty_after_pop");

    // Frame cut short before the sequenceId low byte
    ts_frame(1'b0, 16'h88F7, 4'h0, 16'h55AA, 45, 48'd3, 32'd2000, 1'b0);
    rd(ADDR_STATUS, 32'h0, "rx_short_frame");

    // TX frames that must not be timestamped, then msgType boundary
    ts_frame(1'b1, 16'h0800, 4'h0, 16'h0001, 60, 48'd4, 32'd3000, 1'b0);
    rd(ADDR_STATUS, 32'h0, "tx_ipv4_no_push");
    ts_frame(1'b1, 16'h88F7, 4'hB, 16'h0002, 60, 48'd4, 32'd3000, 1'b0);
    rd(ADDR_STATUS, 32'h0, "tx_announce_no_push");
    ts_frame(1'b1, 16'h88F7, 4'h4, 16'h0003, 60, 48'd4, 32'd3000, 1'b0);
    rd(ADDR_STATUS, 32'h0, "tx_msg4_no_push");
    ts_frame(1'b1, 16'h88F7, 4'h3, 16'hBEEF, 60, 48'd7, 32'd4000, 1'b1);
    rd(ADDR_STATUS, 32'h2, "tx_msg3_push");
    chk_head(1'b1);

    // Overflow: five events into a four-entry FIFO
    for (int k = 1; k <= 5; k++)
      ts_frame(1'b1, 16'h88F7, 4'(k % 4), 16'(k), 60, 48'(k), 32'(100 * k), k <= 4);
    rd(ADDR_STATUS, 32'hA, "tx_full_ovf");
    for (int k = 0; k < 4; k++) chk_head(1'b1);
    rd(ADDR_STATUS, 32'h8, "tx_empty_ovf_sticky");
    wr(ADDR_CTRL, bit32(CTRL_TX_POP));
    rd(ADDR_STATUS, 32'h8, "tx_pop_empty_noop");
    wr(ADDR_STATUS, 32'h8);
    rd(ADDR_STATUS, 32'h0, "tx_ovf_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
